bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data width of both requester data inputs and of out.
REQ-002 Parameter MAX_BURST, default 4: maximum number of consecutive beats granted to one requester while the other requester waits.
REQ-003 clock  input  1  rising-edge clock; the block has one clock only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 requests the bus.
REQ-006 req1  input  1  requester 1 requests the bus.
REQ-007 data0  input  WIDTH  requester 0 data.
REQ-008 data1  input  WIDTH  requester 1 data.
REQ-009 ready  input  1  sink accepts a beat this cycle.
REQ-010 grant0  output  1  requester 0 owns the bus.
REQ-011 grant1  output  1  requester 1 owns the bus.
REQ-012 sel  output  1  mux select (0 = data0, 1 = data1).
REQ-013 out  output  WIDTH  registered transferred data.
REQ-014 valid  output  1  out holds a beat transferred in the previous cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1; grant0/grant1 SHALL be high only in GRANT0/GRANT1 respectively, and never both high.
REQ-016 In IDLE, a lone reqX SHALL move the FSM to GRANTX on the next edge (grant one cycle after the request).
REQ-017 In IDLE with req0 and req1 both high, the FSM SHALL grant the requester other than the last one served (register last, 1 after reset, so requester 0 wins first).
REQ-018 sel SHALL equal X in GRANTX and SHALL hold its previous value in IDLE.
REQ-019 A beat SHALL occur in GRANTX when reqX and ready are both high in that cycle.
REQ-020 On a beat, out SHALL load dataX and valid SHALL be 1 on the next cycle; otherwise valid SHALL be 0 and out SHALL hold its value.
REQ-021 A 0..MAX_BURST-1 burst counter SHALL increment on each beat and clear on every state change.
REQ-022 In GRANTX with reqX low, the next state SHALL be GRANT(other) if the other request is high, else IDLE; no beat occurs in that cycle.
REQ-023 On a beat with count = MAX_BURST-1 and the other request high, the next state SHALL be GRANT(other) and last SHALL become X.
REQ-024 On a beat with count = MAX_BURST-1 and the other request low, the FSM SHALL stay in GRANTX and the counter SHALL wrap to 0.
REQ-025 With ready low, grant, sel, count and state SHALL hold (except on reqX drop, which follows REQ-022).
REQ-026 On every exit from GRANTX, last SHALL be set to X.

Reset
REQ-027 While reset is high at a clock edge: state IDLE, grant0 = grant1 = 0, sel 0, out 0, valid 0, count 0, last 1.
REQ-028 reset asserted mid-burst SHALL abort the burst; no valid beat SHALL appear on the cycle after reset.
REQ-029 Reset SHALL take priority over all requests and ready.

Structure
REQ-030 The state encoding (IDLE/GRANT0/GRANT1) and the WIDTH/MAX_BURST defaults SHALL reside in a shared package, bus_arbiter_pkg.
REQ-031 The burst counter SHALL be a single sub-module, burst_counter (inc, clr, wrap flag); the data mux and output register SHALL stay inline.

Verification
REQ-032 Reset: assert reset for 2 cycles mid-burst -> grant0 = grant1 = 0, valid 0, out 0x0000 on the following cycle.
REQ-033 Single requester: req0 = 1, data0 = 0x0061, ready = 1 -> grant0 high at cycle +1; out = 0x0061, valid = 1 at cycle +2.
REQ-034 Simultaneous first request: req0 = req1 = 1 from IDLE after reset -> grant0 first; after 4 beats grant1, sel = 1, out = data1.
REQ-035 Burst limit: both requests held, ready = 1 -> grants alternate every 4 beats (0,0,0,0,1,1,1,1,0...).
REQ-036 Stall: in GRANT1, ready = 0 for 3 cycles -> valid = 0, grant1 held, count unchanged; beats resume once ready = 1.
REQ-037 Request drop: in GRANT0 after 2 beats, req0 falls with req1 high -> grant1 next cycle, counter cleared; with req1 low -> IDLE, sel stays 0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester bus arbiter.
// Holds the FSM state encoding, default sizing and small helpers.
package bus_arbiter_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  // Counter width that stays legal even for a burst limit of one beat.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic state_t grant_state(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus between the two requesters, the sink and the arbiter.
// The master side drives requests/data/ready; the slave side is the arbiter.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             ready;
  logic             grant0;
  logic             grant1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             valid;

  modport master (
    output req0, req1, data0, data1, ready,
    input  grant0, grant1, sel, out, valid
  );

  modport slave (
    input  req0, req1, data0, data1, ready,
    output grant0, grant1, sel, out, valid
  );

endinterface

// File: rtl/bus_arbiter_burst_counter.sv
// Beat counter for the current owner: counts 0..MAX_BURST-1 and flags the last slot.
// A clear wins over an increment so every ownership change starts a fresh burst.
module burst_counter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic wrap
);

  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign wrap = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter with fair tie-break and a per-owner burst limit.
// Transferred beats are muxed by sel and registered onto out/valid.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic             last_d;
  logic             sel_q;
  logic             sel_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             valid_q;
  logic             valid_d;

  logic             owner;
  logic             own_req;
  logic             other_req;
  logic             beat;
  logic             burst_clr;
  logic             burst_wrap;
  logic [WIDTH-1:0] mux_data;

  // Only meaningful in the grant states; in IDLE these values are ignored.
  assign owner     = (state_q == ST_GRANT1);
  assign own_req   = owner ? bus.req1 : bus.req0;
  assign other_req = owner ? bus.req0 : bus.req1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = last_q ? ST_GRANT0 : ST_GRANT1;
        end else if (bus.req0) begin
          state_d = ST_GRANT0;
        end else if (bus.req1) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!own_req) begin
          last_d  = owner;
          state_d = other_req ? grant_state(~owner) : ST_IDLE;
        end else if (bus.ready) begin
          beat = 1'b1;
          // Burst limit reached with a waiter: hand over; otherwise the counter wraps.
          if (burst_wrap && other_req) begin
            last_d  = owner;
            state_d = grant_state(~owner);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (state_d == ST_GRANT0) begin
      sel_d = 1'b0;
    end else if (state_d == ST_GRANT1) begin
      sel_d = 1'b1;
    end
  end

  assign burst_clr = (state_d != state_q);

  burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .clock (clock),
    .reset (reset),
    .inc   (beat),
    .clr   (burst_clr),
    .wrap  (burst_wrap)
  );

  assign mux_data = sel_q ? bus.data1 : bus.data0;

  always_comb begin
    out_d   = beat ? mux_data : out_q;
    valid_d = beat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.grant0 = (state_q == ST_GRANT0);
  assign bus.grant1 = (state_q == ST_GRANT1);
  assign bus.sel    = sel_q;
  assign bus.out    = out_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues the expected post-edge outputs,
// a negedge monitor pops and compares them against the interface.
module tb_bus_arbiter;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        sel;
    logic        v;
    logic [15:0] dout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  bus_arbiter_if #(.WIDTH(16)) bus ();

  bus_arbiter #(
    .WIDTH     (16),
    .MAX_BURST (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string field, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  exp_t  mon_e;
  string mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      cmp(mon_nm, "grant0", {15'd0, bus.grant0}, {15'd0, mon_e.g0});
      cmp(mon_nm, "grant1", {15'd0, bus.grant1}, {15'd0, mon_e.g1});
      cmp(mon_nm, "sel",    {15'd0, bus.sel},    {15'd0, mon_e.sel});
      cmp(mon_nm, "valid",  {15'd0, bus.valid},  {15'd0, mon_e.v});
      cmp(mon_nm, "out",    bus.out,             mon_e.dout);
      $display("txn %-10s g0=%b g1=%b sel=%b valid=%b out=%h", mon_nm,
               bus.grant0, bus.grant1, bus.sel, bus.valid, bus.out);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic cyc(input logic r, input logic r0, input logic r1,
                     input logic [15:0] d0, input logic [15:0] d1, input logic rdy,
                     input logic eg0, input logic eg1, input logic esel, input logic ev,
                     input logic [15:0] eout, input string nm);
    exp_t e;
    rst       = r;
    bus.req0  = r0;
    bus.req1  = r1;
    bus.data0 = d0;
    bus.data1 = d1;
    bus.ready = rdy;
    e = '{g0: eg0, g1: eg1, sel: esel, v: ev, dout: eout};
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    logic own_pre;
    logic own_post;
    logic [15:0] d0;
    logic [15:0] d1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.ready = 1'b0;
    bus.data0 = '0;  bus.data1 = '0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0000, "reset");
    cyc(1, 1, 1, 16'hFFFF, 16'hEEEE, 1, 0, 0, 0, 0, 16'h0000, "reset_pri");

    // Single requester: grant at +1, data at +2, then drop to IDLE
    cyc(0, 1, 0, 16'h0061, 16'h0, 1, 1, 0, 0, 0, 16'h0000, "single_g");
    cyc(0, 1, 0, 16'h0061, 16'h0, 1, 1, 0, 0, 1, 16'h0061, "single_d");
    cyc(0, 0, 0, 16'h0062, 16'h0, 1, 0, 0, 0, 0, 16'h0061, "single_idle");

    // Fresh reset, then simultaneous requests: requester 0 first, alternate every 4 beats
    cyc(1, 1, 1, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0000, "reset2");
    cyc(1, 1, 1, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0000, "reset2");
    cyc(0, 1, 1, 16'h1000, 16'h2000, 1, 1, 0, 0, 0, 16'h0000, "tie_first");
    for (int k = 1; k <= 14; k++) begin
      own_pre  = 1'(((k - 1) >> 2) & 1);
      own_post = 1'((k >> 2) & 1);
      d0 = 16'h1000 + 16'(k);
      d1 = 16'h2000 + 16'(k);
      cyc(0, 1, 1, d0, d1, 1, ~own_post, own_post, own_post, 1, own_pre ? d1 : d0, "burst");
    end

    // Reset for two cycles mid-burst, then quiet cycle: nothing valid
    cyc(1, 1, 1, 16'hAAAA, 16'hBBBB, 1, 0, 0, 0, 0, 16'h0000, "mid_reset");
    cyc(1, 1, 1, 16'hAAAA, 16'hBBBB, 1, 0, 0, 0, 0, 16'h0000, "mid_reset");
    cyc(0, 0, 0, 16'hAAAA, 16'hBBBB, 1, 0, 0, 0, 0, 16'h0000, "post_reset");

    // Stall in GRANT1: ready low holds grant and burst count
    cyc(0, 0, 1, 16'h0, 16'h3001, 0, 0, 1, 1, 0, 16'h0000, "stall_g1");
    cyc(0, 0, 1, 16'h0, 16'h3002, 1, 0, 1, 1, 1, 16'h3002, "stall_b1");
    cyc(0, 1, 1, 16'h4003, 16'h3003, 0, 0, 1, 1, 0, 16'h3002, "stall");
    cyc(0, 1, 1, 16'h4004, 16'h3004, 0, 0, 1, 1, 0, 16'h3002, "stall");
    cyc(0, 1, 1, 16'h4005, 16'h3005, 0, 0, 1, 1, 0, 16'h3002, "stall");
    cyc(0, 1, 1, 16'h4006, 16'h3006, 1, 0, 1, 1, 1, 16'h3006, "resume_b2");
    cyc(0, 1, 1, 16'h4007, 16'h3007, 1, 0, 1, 1, 1, 16'h3007, "resume_b3");
    cyc(0, 1, 1, 16'h4008, 16'h3008, 1, 1, 0, 0, 1, 16'h3008, "resume_b4");

    // Request drop with the other requester waiting
    cyc(0, 1, 1, 16'h4009, 16'h3009, 1, 1, 0, 0, 1, 16'h4009, "drop_b1");
    cyc(0, 1, 1, 16'h400A, 16'h300A, 1, 1, 0, 0, 1, 16'h400A, "drop_b2");
    cyc(0, 0, 1, 16'h400B, 16'h300B, 1, 0, 1, 1, 0, 16'h400A, "drop_sw");
    for (int i = 0; i < 4; i++) begin
      d1 = 16'h5000 + 16'(i);
      if (i == 3) cyc(0, 1, 1, 16'h4100, d1, 1, 1, 0, 0, 1, d1, "drop_cnt");
      else        cyc(0, 1, 1, 16'h4100, d1, 1, 0, 1, 1, 1, d1, "drop_cnt");
    end

    // Request drop with nobody waiting: IDLE, sel holds 0
    cyc(0, 1, 0, 16'h6001, 16'h0, 1, 1, 0, 0, 1, 16'h6001, "idle_b1");
    cyc(0, 1, 0, 16'h6002, 16'h0, 1, 1, 0, 0, 1, 16'h6002, "idle_b2");
    cyc(0, 0, 0, 16'h6003, 16'h0, 1, 0, 0, 0, 0, 16'h6002, "idle_sel0");
    cyc(0, 0, 0, 16'h6004, 16'h0, 1, 0, 0, 0, 0, 16'h6002, "idle_sel0");

    // sel holds 1 in IDLE after GRANT1, and the tie goes to requester 0
    cyc(0, 0, 1, 16'h0, 16'h7001, 0, 0, 1, 1, 0, 16'h6002, "g1_nordy");
    cyc(0, 0, 0, 16'h0, 16'h7002, 1, 0, 0, 1, 0, 16'h6002, "idle_sel1");
    cyc(0, 0, 0, 16'h0, 16'h7003, 1, 0, 0, 1, 0, 16'h6002, "idle_sel1");
    cyc(0, 1, 1, 16'h8000, 16'h9000, 1, 1, 0, 0, 0, 16'h6002, "tie_last1");

    // Lone requester wraps the counter and keeps the bus
    for (int i = 0; i < 8; i++) begin
      d0 = 16'h8001 + 16'(i);
      if (i < 5)       cyc(0, 1, 0, d0, 16'h9000, 1, 1, 0, 0, 1, d0, "wrap_solo");
      else if (i < 7)  cyc(0, 1, 1, d0, 16'h9000, 1, 1, 0, 0, 1, d0, "wrap_wait");
      else             cyc(0, 1, 1, d0, 16'h9000, 1, 0, 1, 1, 1, d0, "wrap_sw");
    end

    @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
